// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mult_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FINISH
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The partial remainder is always below the divisor, so the difference fits WIDTH bits.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted[WIDTH-1:0] - divisor_i;
        q_o     = (shifted >= {1'b0, divisor_i});
        rem_o   = q_o ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / restoring divide with HI/LO result registers.
// Optional MULT_DIV_UNSIGNED_EN adds the Unsigned input for multu/divu.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             Unsigned,
`endif
    input  logic             clock,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done,
    output logic             Div0
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d;
    logic                 qneg_q, qneg_d, rneg_q, rneg_d;
    logic                 is_div_q, is_div_d, zero_q, zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d, div0_q, div0_d;
    logic                 uns_start, uns;
    logic [WIDTH:0]       booth_sum;
    logic [WIDTH-1:0]     acc_hi, acc_lo, step_rem;
    logic                 step_q, last_step;

`ifdef MULT_DIV_UNSIGNED_EN
    logic uns_q, uns_d;
    assign uns_start = Unsigned;
    assign uns       = uns_q;
`else
    assign uns_start = 1'b0;
    assign uns       = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic u);
        return (!u && v[WIDTH-1]) ? -v : v;
    endfunction

    assign acc_hi    = acc_q[2*WIDTH:WIDTH+1];
    assign acc_lo    = acc_q[WIDTH:1];
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (mcand_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Sum is kept one bit wider so that subtracting the most negative multiplicand
    // cannot overflow before the arithmetic shift.
    always_comb begin
        booth_sum = {acc_hi[WIDTH-1], acc_hi};
        if (uns) begin
            booth_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_q} : '0);
        end else begin
            unique case ({acc_lo[0], acc_q[0]})
                2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {mcand_q[WIDTH-1], mcand_q};
                2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {mcand_q[WIDTH-1], mcand_q};
                default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (MultCtrl)     state_d = MULT;
                else if (DivCtrl) state_d = (B == '0) ? FINISH : DIV;
            end
            MULT:    if (last_step) state_d = FINISH;
            DIV:     if (last_step) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
`ifdef MULT_DIV_UNSIGNED_EN
        uns_d    = uns_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (MultCtrl || DivCtrl) begin
                    cnt_d    = '0;
                    div0_d   = 1'b0;
                    zero_d   = 1'b0;
                    is_div_d = !MultCtrl;
`ifdef MULT_DIV_UNSIGNED_EN
                    uns_d    = uns_start;
`endif
                    if (MultCtrl) begin
                        mcand_d = A;
                        acc_d   = {{WIDTH{1'b0}}, B, 1'b0};
                    end else if (B == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        mcand_d = mag(B, uns_start);
                        quo_d   = mag(A, uns_start);
                        rem_d   = '0;
                        qneg_d  = !uns_start && (A[WIDTH-1] ^ B[WIDTH-1]);
                        rneg_d  = !uns_start && A[WIDTH-1];
                    end
                end
            end
            MULT: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = {booth_sum, acc_lo};
            end
            DIV: begin
                cnt_d = cnt_q + CW'(1);
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q};
            end
            FINISH: begin
                done_d = 1'b1;
                if (zero_q) begin
                    div0_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = qneg_q ? -quo_q : quo_q;
                    hi_d = rneg_q ? -rem_q : rem_q;
                end else begin
                    hi_d = acc_hi;
                    lo_d = acc_lo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
            uns_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
`ifdef MULT_DIV_UNSIGNED_EN
            uns_q    <= uns_d;
`endif
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign Div0 = div0_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle signed multiply/divide responder for the multicycle MIPS datapath. It accepts one-cycle start pulses from the control unit (MultCtrl for mult, DivCtrl for div) with operands taken from registers A and B. It iterates WIDTH cycles, then updates the HI/LO result registers and pulses Done. It reports divide-by-zero on Div0, which the control unit consumes to raise the exception path.

Parameters:
WIDTH, 32, operand/result width; also the iteration count.

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
MultCtrl  input  1  start signed multiply; sampled only in IDLE
DivCtrl  input  1  start signed divide; sampled only in IDLE
A  input  WIDTH  multiplicand / dividend; sampled on the accepted start edge
B  input  WIDTH  multiplier / divisor; sampled on the accepted start edge
HI  output  WIDTH  mult: upper product half; div: remainder
LO  output  WIDTH  mult: lower product half; div: quotient
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse when HI/LO are updated or Div0 is raised
Div0  output  1  divide-by-zero flag; sticky until next accepted start or reset

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, any time, including mid-operation):
  - state=IDLE.
  - HI=0, LO=0, Busy=0, Done=0, Div0=0.
  - Internal accumulators and counter cleared.
  - A start pulse on the first edge after reset release is accepted.
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - At edge E0 with MultCtrl=1: latch A, B; counter=0; go to MULT.
  - At E0 with DivCtrl=1 and B!=0: latch A, B; go to DIV.
  - At E0 with DivCtrl=1 and B==0: go to FINISH with the zero-divisor flag set.
  - MultCtrl and DivCtrl both high: MultCtrl wins.
  - Busy=1 from E0 onward.
- MULT: radix-2 Booth, one step per edge, WIDTH steps, over a 2*WIDTH+1-bit accumulator with arithmetic shift right. After step WIDTH, go to FINISH.
- DIV:
  - Restoring division on operand magnitudes, one quotient bit per edge, WIDTH steps, then FINISH.
  - Sign fix-up in FINISH: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 wraps: LO=0x80000000, HI=0. No flag.
- FINISH (one cycle):
  - Normal case: HI/LO written, Done=1, Busy=0 on the following edge, return to IDLE.
  - Zero divisor: HI/LO unchanged, Div0=1, Done=1.
- Latency:
  - mult/div: HI/LO valid and Done=1 in the cycle after edge E0+WIDTH+1 (E0+33 for WIDTH=32).
  - Zero divisor: Div0=1, Done=1 after E0+1.
- Start pulses while Busy are ignored; no queueing.
- HI/LO hold their value between operations.
- Div0 clears on the next accepted start.

Optional Feature:
Macro MULT_DIV_UNSIGNED_EN.
- Defined: adds input port Unsigned (1 bit), sampled with the start. Unsigned=1 performs multu/divu: zero-extended accumulator, no sign fix-up, no wrap case.
- Undefined: port absent; all operations signed.

Decomposition:
- Package mult_div_pkg holds:
  - the state enum (IDLE, MULT, DIV, FINISH);
  - the default WIDTH constant;
  - the counter width localparam ($clog2(WIDTH)+1).
- One natural sub-module: div_step, a combinational restoring-division step (partial remainder in, shifted remainder and quotient bit out), instantiated once and iterated by the FSM.

Test Plan:
- mult A=7, B=0xFFFFFFFD (-3) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done high exactly one cycle after E0+33; Busy low after.
- mult A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); Div0=0.
- div A=5, B=0 with HI=0x11, LO=0x22 preloaded -> Div0=1 and Done after E0+1; HI/LO unchanged; a following mult 2*3 clears Div0 and gives LO=6, HI=0.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; no Div0.
- reset=0 asserted 10 cycles into a mult -> all outputs 0 immediately (asynchronous). A MultCtrl pulse during Busy of a later op is ignored (result unchanged, single Done).
